// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, synchronized row sampling, scan debounce.
// Optional auto-repeat pulses on a held key when KEYPAD_REPEAT_EN is defined.
`timescale 1ns/1ps
module keypad_scanner #(
  parameter int SETTLE_CYCLES  = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 50
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] button,
  output logic       is_pressed
);

  localparam int SET_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 2;
  localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [1:0] K_NONE   = 2'd0;
  localparam logic [1:0] K_SINGLE = 2'd1;
  localparam logic [1:0] K_MULTI  = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_EVAL} state_t;

  state_t           r_state, w_state_nx;
  logic [1:0]       r_col_idx, w_col_idx_nx;
  logic [SET_W-1:0] r_settle, w_settle_nx;
  logic [3:0]       r_col, w_col_nx;
  logic [3:0]       r_row_p0, r_row_p1;
  logic [15:0]      r_scan;
  logic [4:0]       w_low_cnt;
  logic [3:0]       w_code;
  logic [5:0]       w_res;
  logic [5:0]       r_prev;
  logic [DB_W-1:0]  r_stable;
  logic             w_same, w_accept, w_new_key, w_release;
  logic [3:0]       r_button;
  logic             r_pressed, r_held, r_repress;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b0000: code = 4'h1;
      4'b0001: code = 4'h2;
      4'b0010: code = 4'h3;
      4'b0011: code = 4'hA;
      4'b0100: code = 4'h4;
      4'b0101: code = 4'h5;
      4'b0110: code = 4'h6;
      4'b0111: code = 4'hB;
      4'b1000: code = 4'h7;
      4'b1001: code = 4'h8;
      4'b1010: code = 4'h9;
      4'b1011: code = 4'hC;
      4'b1100: code = 4'h0;
      4'b1101: code = 4'hF;
      4'b1110: code = 4'hE;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Stage p0/p1: two-flop row synchronizer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_row_p0 <= 4'hF;
      r_row_p1 <= 4'hF;
    end else begin
      r_row_p0 <= row;
      r_row_p1 <= r_row_p0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_col_idx <= 2'd0;
      r_settle  <= '0;
      r_col     <= 4'b1111;
    end else begin
      r_state   <= w_state_nx;
      r_col_idx <= w_col_idx_nx;
      r_settle  <= w_settle_nx;
      r_col     <= w_col_nx;
    end
  end

  // col is registered from the next state so it never glitches between states
  always_comb begin
    w_state_nx   = r_state;
    w_col_idx_nx = r_col_idx;
    w_settle_nx  = r_settle;
    w_col_nx     = 4'b1111;
    case (r_state)
      S_IDLE, S_EVAL: begin
        w_state_nx   = S_DRIVE;
        w_col_idx_nx = 2'd0;
        w_settle_nx  = '0;
      end
      S_DRIVE: begin
        if (r_settle == SET_W'(SETTLE_CYCLES - 1)) w_state_nx = S_SAMPLE;
        else w_settle_nx = r_settle + SET_W'(1);
      end
      S_SAMPLE: begin
        w_settle_nx = '0;
        if (r_col_idx == 2'd3) begin
          w_state_nx = S_EVAL;
        end else begin
          w_state_nx   = S_DRIVE;
          w_col_idx_nx = r_col_idx + 2'd1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
    if (w_state_nx == S_DRIVE || w_state_nx == S_SAMPLE)
      w_col_nx = ~(4'b0001 << w_col_idx_nx);
  end

  // Stage scan: one 4-bit row snapshot per column
  always_ff @(posedge clock) begin
    if (r_state == S_SAMPLE) r_scan[{r_col_idx, 2'b00} +: 4] <= r_row_p1;
  end

  always_comb begin
    w_low_cnt = '0;
    w_code    = 4'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!r_scan[c*4 + r]) begin
          w_low_cnt = w_low_cnt + 5'd1;
          w_code    = key_code(2'(r), 2'(c));
        end
      end
    end
    if (w_low_cnt == 5'd0)      w_res = {K_NONE, 4'h0};
    else if (w_low_cnt == 5'd1) w_res = {K_SINGLE, w_code};
    else                        w_res = {K_MULTI, 4'h0};
  end

  // Accept exactly on the EVAL where the stable count first reaches its target
  assign w_same    = (w_res == r_prev);
  assign w_accept  = (r_state == S_EVAL) &&
                     (w_same ? (r_stable == DB_W'(DEBOUNCE_SCANS - 1))
                             : (DB_W'(DEBOUNCE_SCANS) == DB_W'(1)));
  assign w_new_key = w_accept && (w_res[5:4] == K_SINGLE) &&
                     (!r_held || (r_button != w_res[3:0]));
  assign w_release = w_accept && (w_res[5:4] == K_NONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prev   <= {K_NONE, 4'h0};
      r_stable <= '0;
    end else if (r_state == S_EVAL) begin
      if (w_same) begin
        if (r_stable != DB_W'(DEBOUNCE_SCANS)) r_stable <= r_stable + DB_W'(1);
      end else begin
        r_prev   <= w_res;
        r_stable <= DB_W'(1);
      end
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RP_W = $clog2(REPEAT_SCANS + 1);

  logic [RP_W-1:0] r_rpt_cnt;
  logic            w_rpt_fire;

  assign w_rpt_fire = (r_state == S_EVAL) && r_held &&
                      (r_rpt_cnt == RP_W'(REPEAT_SCANS - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rpt_cnt <= '0;
    end else if (w_new_key || w_release) begin
      r_rpt_cnt <= '0;
    end else if (r_state == S_EVAL && r_held) begin
      r_rpt_cnt <= w_rpt_fire ? '0 : r_rpt_cnt + RP_W'(1);
    end
  end
`endif

  // r_repress restores is_pressed one cycle after a key-change or repeat dip
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_button  <= 4'h0;
      r_pressed <= 1'b0;
      r_held    <= 1'b0;
      r_repress <= 1'b0;
    end else begin
      if (r_repress) begin
        r_pressed <= 1'b1;
        r_repress <= 1'b0;
      end
      if (w_new_key) begin
        r_button <= w_res[3:0];
        r_held   <= 1'b1;
        if (r_held) begin
          r_pressed <= 1'b0;
          r_repress <= 1'b1;
        end else begin
          r_pressed <= 1'b1;
        end
      end else if (w_release) begin
        r_pressed <= 1'b0;
        r_held    <= 1'b0;
        r_repress <= 1'b0;
      end
`ifdef KEYPAD_REPEAT_EN
      else if (w_rpt_fire) begin
        r_pressed <= 1'b0;
        r_repress <= 1'b1;
      end
`endif
    end
  end

  assign col        = r_col;
  assign button     = r_button;
  assign is_pressed = r_pressed;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a combinational keypad matrix model.
// Parameters: SETTLE_CYCLES=4, DEBOUNCE_SCANS=3, REPEAT_SCANS=5 (scan period 21 cycles).
`timescale 1ns/1ps
module tb_keypad_scanner;
  localparam int SETTLE = 4;
  localparam int DEB    = 3;
  localparam int REP    = 5;
  localparam int T      = 4 * (SETTLE + 1) + 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  button;
  logic        is_pressed;
  logic [15:0] keys = '0;   // index = col*4 + row, 1 = key pressed
  int          cyc;
  int          n_cmp = 0;
  int          n_bad = 0;

  keypad_scanner #(
    .SETTLE_CYCLES (SETTLE),
    .DEBOUNCE_SCANS(DEB),
    .REPEAT_SCANS  (REP)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .button    (button),
    .is_pressed(is_pressed)
  );

  always #5 clock = ~clock;

  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[c*4 + r] && !col[c]) row[r] = 1'b0;
  end

  // Cycle n begins at the n-th rising edge after reset release
  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic at_cycle(input int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset(input logic [15:0] k);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    keys  = k;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    keys  = '0;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++;
    if (col !== 4'b1111) begin n_bad++; $display("FAIL reset_col got=%b want=%b", col, 4'b1111); end
    n_cmp++;
    if (button !== 4'h0) begin n_bad++; $display("FAIL reset_button got=%h want=%h", button, 4'h0); end
    n_cmp++;
    if (is_pressed !== 1'b0) begin n_bad++; $display("FAIL reset_pressed got=%b want=%b", is_pressed, 1'b0); end
  endtask

  task automatic test_scan_sequence;
    logic [3:0] exp_col;
    int         bad;
    int         p;
    do_reset('0);
    #1;
    n_cmp++;
    if (col !== 4'b1111) begin n_bad++; $display("FAIL scan_col_cycle0 got=%b want=%b", col, 4'b1111); end
    bad = 0;
    for (int c = 1; c <= 2 * T + 1; c++) begin
      at_cycle(c);
      p = (c - 1) % T;
      if (p == T - 1) exp_col = 4'b1111;
      else            exp_col = ~(4'b0001 << (p / (SETTLE + 1)));
      if (col !== exp_col) begin
        bad++;
        if (bad < 4) $display("FAIL scan_col cycle=%0d got=%b want=%b", c, col, exp_col);
      end
    end
    n_cmp++;
    if (bad != 0) n_bad++;
  endtask

  task automatic test_press_release;
    int bad;
    do_reset(16'h0020);   // key '5': row1, col1
    at_cycle(63);
    n_cmp++;
    if (is_pressed !== 1'b0) begin n_bad++; $display("FAIL key5_early got=%b want=%b", is_pressed, 1'b0); end
    at_cycle(64);
    n_cmp++;
    if (is_pressed !== 1'b1) begin n_bad++; $display("FAIL key5_press got=%b want=%b", is_pressed, 1'b1); end
    n_cmp++;
    if (button !== 4'h5) begin n_bad++; $display("FAIL key5_button got=%h want=%h", button, 4'h5); end
    keys = '0;
    bad = 0;
    for (int c = 65; c <= 126; c++) begin
      at_cycle(c);
      if (is_pressed !== 1'b1 || button !== 4'h5) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL key5_hold bad_cycles=%0d want=0", bad); end
    at_cycle(127);
    n_cmp++;
    if (is_pressed !== 1'b0) begin n_bad++; $display("FAIL key5_release got=%b want=%b", is_pressed, 1'b0); end
    n_cmp++;
    if (button !== 4'h5) begin n_bad++; $display("FAIL key5_button_kept got=%h want=%h", button, 4'h5); end
  endtask

  task automatic test_bounce;
    int bad;
    do_reset('0);
    at_cycle(22);
    for (int t = 0; t < 6; t++) begin
      at_cycle(22 + 7 * t);
      keys[11] = ~t[0];   // key 'E': row3, col2
    end
    at_cycle(62);
    keys[11] = 1'b1;
    bad = 0;
    for (int c = 62; c <= 105; c++) begin
      at_cycle(c);
      if (is_pressed !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL bounce_early bad_cycles=%0d want=0", bad); end
    at_cycle(106);
    n_cmp++;
    if (is_pressed !== 1'b1) begin n_bad++; $display("FAIL bounce_press got=%b want=%b", is_pressed, 1'b1); end
    n_cmp++;
    if (button !== 4'hE) begin n_bad++; $display("FAIL bounce_button got=%h want=%h", button, 4'hE); end
  endtask

  task automatic test_key_change;
    do_reset(16'h0001);   // key '1': row0, col0
    at_cycle(64);
    n_cmp++;
    if (is_pressed !== 1'b1 || button !== 4'h1) begin
      n_bad++; $display("FAIL change_first got=%b/%h want=1/1", is_pressed, button);
    end
    keys = 16'h0010;      // key '2': row0, col1
    at_cycle(126);
    n_cmp++;
    if (is_pressed !== 1'b1 || button !== 4'h1) begin
      n_bad++; $display("FAIL change_before got=%b/%h want=1/1", is_pressed, button);
    end
    at_cycle(127);
    n_cmp++;
    if (is_pressed !== 1'b0 || button !== 4'h2) begin
      n_bad++; $display("FAIL change_dip got=%b/%h want=0/2", is_pressed, button);
    end
    at_cycle(128);
    n_cmp++;
    if (is_pressed !== 1'b1 || button !== 4'h2) begin
      n_bad++; $display("FAIL change_after got=%b/%h want=1/2", is_pressed, button);
    end
  endtask

  task automatic test_multi;
    int bad;
    do_reset(16'h1100);   // keys '3' (row0,col2) and 'A' (row0,col3)
    at_cycle(64);
    keys = 16'h0100;
    bad = 0;
    for (int c = 64; c <= 126; c++) begin
      at_cycle(c);
      if (is_pressed !== 1'b0 || button !== 4'h0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL multi_unchanged bad_cycles=%0d want=0", bad); end
    at_cycle(127);
    n_cmp++;
    if (is_pressed !== 1'b1 || button !== 4'h3) begin
      n_bad++; $display("FAIL multi_then_3 got=%b/%h want=1/3", is_pressed, button);
    end
  endtask

  task automatic test_repeat;
    int  lows;
    int  bad;
    int  want_lows;
    logic exp_p;
    do_reset(16'h0008);   // key '0': row3, col0
    at_cycle(64);
    n_cmp++;
    if (is_pressed !== 1'b1 || button !== 4'h0) begin
      n_bad++; $display("FAIL repeat_accept got=%b/%h want=1/0", is_pressed, button);
    end
    lows = 0;
    bad  = 0;
    for (int c = 65; c <= 64 + 20 * T - 5; c++) begin
      at_cycle(c);
`ifdef KEYPAD_REPEAT_EN
      exp_p = ((c - 64) % (REP * T) == 0) ? 1'b0 : 1'b1;
`else
      exp_p = 1'b1;
`endif
      if (is_pressed === 1'b0) lows++;
      if (is_pressed !== exp_p) begin
        bad++;
        if (bad < 4) $display("FAIL repeat_level cycle=%0d got=%b want=%b", c, is_pressed, exp_p);
      end
    end
`ifdef KEYPAD_REPEAT_EN
    want_lows = 3;
`else
    want_lows = 0;
`endif
    n_cmp++;
    if (bad != 0) n_bad++;
    n_cmp++;
    if (lows != want_lows) begin n_bad++; $display("FAIL repeat_pulses got=%0d want=%0d", lows, want_lows); end
  endtask

  task automatic test_mid_reset;
    do_reset(16'h0020);
    at_cycle(70);
    n_cmp++;
    if (col !== 4'b1101 || is_pressed !== 1'b1 || button !== 4'h5) begin
      n_bad++; $display("FAIL midrst_before got=%b/%b/%h want=1101/1/5", col, is_pressed, button);
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (col !== 4'b1111 || is_pressed !== 1'b0 || button !== 4'h0) begin
      n_bad++; $display("FAIL midrst_async got=%b/%b/%h want=1111/0/0", col, is_pressed, button);
    end
    @(negedge clock);
    reset = 1'b0;
    at_cycle(1);
    n_cmp++;
    if (col !== 4'b1110) begin n_bad++; $display("FAIL midrst_restart got=%b want=%b", col, 4'b1110); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_scan_sequence();
    test_press_release();
    test_bounce();
    test_key_change();
    test_multi();
    test_repeat();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
